// File: rtl/hpi_responder.sv
// ============================================================================
// hpi_responder : HPI register-set responder (DATA/MAILBOX/ADDRESS/STATUS)
// Rev 1.0
// ============================================================================
`default_nettype none

module hpi_responder #(
  parameter int MEM_WORDS = 1024,
  parameter int MEM_AW    = 10
) (
  input  logic        clk_clk,
  input  logic        reset_reset,
  input  logic [1:0]  otg_hpi_address,
  input  logic        otg_hpi_cs_n,
  input  logic        otg_hpi_r_n,
  input  logic        otg_hpi_w_n,
  input  logic [15:0] otg_hpi_data_in,
  output logic [15:0] otg_hpi_data_out,
  output logic        otg_hpi_data_oe,
  output logic        hpi_int,
  output logic [15:0] dev_mbx_rdata,
  output logic        dev_mbx_full,
  input  logic        dev_mbx_ack,
  input  logic [15:0] dev_mbx_wdata,
  input  logic        dev_mbx_wr
);

  localparam logic [1:0] REG_DATA = 2'd0;
  localparam logic [1:0] REG_MBX  = 2'd1;
  localparam logic [1:0] REG_ADDR = 2'd2;
  localparam logic [1:0] REG_STAT = 2'd3;

  logic              active;
  logic              prev_active;
  logic              start;
  logic              rd_start;
  logic              wr_start;
  logic [15:0]       addr;
  logic              in_range;
  logic [MEM_AW-1:0] word_idx;
  logic              ram_we;
  logic              ram_re;
  logic [15:0]       ram_q;
  logic [15:0]       mem [MEM_WORDS];
  logic [15:0]       h2d_word;
  logic              h2d_full;
  logic [15:0]       d2h_word;
  logic              d2h_full;
  logic              overrun;
  logic [15:0]       rd_reg;
  logic [15:0]       rd_mux;
  logic              sel_ram;
  logic              oe;

  // Both strobes low is treated as an idle bus cycle.
  assign active   = ~otg_hpi_cs_n & (otg_hpi_r_n ^ otg_hpi_w_n);
  assign start    = active & ~prev_active;
  assign rd_start = start & ~otg_hpi_r_n;
  assign wr_start = start & ~otg_hpi_w_n;

  assign word_idx = addr[MEM_AW:1];

  generate
    if (MEM_AW >= 15) begin : g_full_map
      assign in_range = 1'b1;
    end else begin : g_part_map
      assign in_range = (addr[15:MEM_AW+1] == '0);
    end
  endgenerate

  assign ram_we = wr_start & (otg_hpi_address == REG_DATA) & in_range & ~reset_reset;
  assign ram_re = rd_start & (otg_hpi_address == REG_DATA) & in_range & ~reset_reset;

  // Single-port synchronous RAM; read port enabled only at access start so the
  // word stays stable while the read strobe is held.
  always_ff @(posedge clk_clk) begin
    if (ram_we) begin
      mem[word_idx] <= otg_hpi_data_in;
    end
    if (ram_re) begin
      ram_q <= mem[word_idx];
    end
  end

  always_comb begin
    rd_mux = 16'h0000;
    unique case (otg_hpi_address)
      REG_DATA: rd_mux = 16'h0000;
      REG_MBX:  rd_mux = d2h_word;
      REG_ADDR: rd_mux = addr;
      REG_STAT: rd_mux = {13'b0, overrun, d2h_full, h2d_full};
      default:  rd_mux = 16'h0000;
    endcase
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      prev_active <= 1'b1;
      addr        <= 16'h0000;
      h2d_word    <= 16'h0000;
      h2d_full    <= 1'b0;
      d2h_word    <= 16'h0000;
      d2h_full    <= 1'b0;
      overrun     <= 1'b0;
      rd_reg      <= 16'h0000;
      sel_ram     <= 1'b0;
      oe          <= 1'b0;
    end else begin
      prev_active <= active;

      // Host-to-device mailbox: a coincident ack frees the slot, so no overrun.
      if (wr_start && otg_hpi_address == REG_MBX) begin
        h2d_word <= otg_hpi_data_in;
        h2d_full <= 1'b1;
        if (h2d_full && !dev_mbx_ack) begin
          overrun <= 1'b1;
        end
      end else if (dev_mbx_ack) begin
        h2d_full <= 1'b0;
      end

      if (rd_start && otg_hpi_address == REG_STAT) begin
        overrun <= 1'b0;
      end

      // Device-to-host mailbox: a device write wins over a host-read clear.
      if (dev_mbx_wr) begin
        d2h_word <= dev_mbx_wdata;
        d2h_full <= 1'b1;
      end else if (rd_start && otg_hpi_address == REG_MBX) begin
        d2h_full <= 1'b0;
      end

      if (wr_start && otg_hpi_address == REG_ADDR) begin
        addr <= otg_hpi_data_in;
      end else if (start && otg_hpi_address == REG_DATA) begin
        addr <= addr + 16'd2;
      end

      if (rd_start) begin
        oe      <= 1'b1;
        sel_ram <= (otg_hpi_address == REG_DATA) & in_range;
        rd_reg  <= rd_mux;
      end else if (!active) begin
        oe      <= 1'b0;
        sel_ram <= 1'b0;
        rd_reg  <= 16'h0000;
      end
    end
  end

  assign otg_hpi_data_out = oe ? (sel_ram ? ram_q : rd_reg) : 16'h0000;
  assign otg_hpi_data_oe  = oe;
  assign hpi_int          = d2h_full;
  assign dev_mbx_rdata    = h2d_word;
  assign dev_mbx_full     = h2d_full;

endmodule

`default_nettype wire

// File: tb/tb_hpi_responder.sv
// Scoreboarded bench for hpi_responder: directed scenarios plus randomized traffic.
`default_nettype none

module tb_hpi_responder;

  localparam int MEM_WORDS = 1024;
  localparam int MEM_AW    = 10;
  localparam logic [1:0] R_DATA = 2'd0;
  localparam logic [1:0] R_MBX  = 2'd1;
  localparam logic [1:0] R_ADDR = 2'd2;
  localparam logic [1:0] R_STAT = 2'd3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  address = 2'd0;
  logic        cs_n = 1'b1;
  logic        r_n = 1'b1;
  logic        w_n = 1'b1;
  logic [15:0] din = 16'h0;
  logic [15:0] dout;
  logic        oe;
  logic        irq;
  logic [15:0] mbx_rdata;
  logic        mbx_full;
  logic        mbx_ack = 1'b0;
  logic [15:0] mbx_wdata = 16'h0;
  logic        mbx_wr = 1'b0;

  hpi_responder #(.MEM_WORDS(MEM_WORDS), .MEM_AW(MEM_AW)) dut (
    .clk_clk          (clk),
    .reset_reset      (rst),
    .otg_hpi_address  (address),
    .otg_hpi_cs_n     (cs_n),
    .otg_hpi_r_n      (r_n),
    .otg_hpi_w_n      (w_n),
    .otg_hpi_data_in  (din),
    .otg_hpi_data_out (dout),
    .otg_hpi_data_oe  (oe),
    .hpi_int          (irq),
    .dev_mbx_rdata    (mbx_rdata),
    .dev_mbx_full     (mbx_full),
    .dev_mbx_ack      (mbx_ack),
    .dev_mbx_wdata    (mbx_wdata),
    .dev_mbx_wr       (mbx_wr)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [15:0] exp_q [$];

  // Reference model state
  logic [15:0] m_mem [MEM_WORDS];
  logic [15:0] m_addr;
  logic [15:0] m_h2d;
  logic        m_full;
  logic [15:0] m_d2h;
  logic        m_int;
  logic        m_ovr;

  // Read monitor: one expected word per rising edge of output-enable.
  logic        oe_d = 1'b0;
  logic [15:0] mon_exp;
  always @(negedge clk) begin
    if (oe && !oe_d) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_read got=%h required=none", dout);
      end else begin
        mon_exp = exp_q.pop_front();
        if (dout !== mon_exp) begin
          n_bad++;
          $display("FAIL read_data got=%h required=%h", dout, mon_exp);
        end
      end
    end
    oe_d = oe;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout required=finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] req);
    n_cmp++;
    if (got !== req) begin
      n_bad++;
      $display("FAIL %s got=%h required=%h", name, got, req);
    end
  endtask

  task automatic check_flags();
    check("dev_mbx_full", {15'b0, mbx_full}, {15'b0, m_full});
    check("dev_mbx_rdata", mbx_rdata, m_h2d);
    check("hpi_int", {15'b0, irq}, {15'b0, m_int});
  endtask

  task automatic model_reset();
    m_addr = 16'h0; m_h2d = 16'h0; m_full = 1'b0;
    m_d2h = 16'h0; m_int = 1'b0; m_ovr = 1'b0;
  endtask

  // One host access with optional device pulses coinciding with its start.
  task automatic access(input bit is_wr, input logic [1:0] r, input logic [15:0] d,
                        input int hold, input bit dwr, input logic [15:0] dwd, input bit dack);
    bit inr;
    inr = (int'(m_addr) < 2 * MEM_WORDS);
    if (is_wr) begin
      case (r)
        R_DATA: begin
          if (inr) m_mem[m_addr[MEM_AW:1]] = d;
          m_addr = m_addr + 16'd2;
        end
        R_MBX: begin
          if (m_full && !dack) m_ovr = 1'b1;
          m_h2d = d;
          m_full = 1'b1;
        end
        R_ADDR: m_addr = d;
        default: ;
      endcase
    end else begin
      case (r)
        R_DATA: begin
          exp_q.push_back(inr ? m_mem[m_addr[MEM_AW:1]] : 16'h0000);
          m_addr = m_addr + 16'd2;
        end
        R_MBX: begin
          exp_q.push_back(m_d2h);
          m_int = 1'b0;
        end
        R_ADDR: exp_q.push_back(m_addr);
        default: begin
          exp_q.push_back({13'b0, m_ovr, m_int, m_full});
          m_ovr = 1'b0;
        end
      endcase
    end
    if (dack && !(is_wr && r == R_MBX)) m_full = 1'b0;
    if (dwr) begin
      m_d2h = dwd;
      m_int = 1'b1;
    end

    @(posedge clk); #1;
    cs_n = 1'b0; address = r; din = d; r_n = is_wr; w_n = !is_wr;
    mbx_wr = dwr; mbx_wdata = dwd; mbx_ack = dack;
    @(posedge clk); #1;
    mbx_wr = 1'b0; mbx_ack = 1'b0;
    repeat (hold - 1) @(posedge clk);
    #1;
    cs_n = 1'b1; r_n = 1'b1; w_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic dev_pulse(input bit dwr, input logic [15:0] dwd, input bit dack);
    if (dack) m_full = 1'b0;
    if (dwr) begin
      m_d2h = dwd;
      m_int = 1'b1;
    end
    @(posedge clk); #1;
    mbx_wr = dwr; mbx_wdata = dwd; mbx_ack = dack;
    @(posedge clk); #1;
    mbx_wr = 1'b0; mbx_ack = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [1:0] r, input logic [15:0] d);
    access(1'b1, r, d, 1, 1'b0, 16'h0, 1'b0);
  endtask

  task automatic rd(input logic [1:0] r);
    access(1'b0, r, 16'h0, 1, 1'b0, 16'h0, 1'b0);
  endtask

  initial begin
    logic [15:0] rdat;
    int guard;
    model_reset();

    // Reset with idle bus
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    check("reset_data_out", dout, 16'h0);
    check("reset_oe", {15'b0, oe}, 16'h0);
    check_flags();
    rd(R_STAT);

    // Strobe held through reset release: no write until re-asserted
    @(posedge clk); #1;
    rst = 1'b1;
    cs_n = 1'b0; address = R_DATA; din = 16'h7777; w_n = 1'b0; r_n = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    repeat (4) @(posedge clk);
    #1 cs_n = 1'b1; w_n = 1'b1;
    @(posedge clk); #1;
    rd(R_ADDR);
    access(1'b1, R_DATA, 16'h7777, 4, 1'b0, 16'h0, 1'b0);
    rd(R_ADDR);
    wr(R_ADDR, 16'h0000);
    rd(R_DATA);

    // Fill the RAM so every later read has a defined expectation
    wr(R_ADDR, 16'h0000);
    for (int i = 0; i < MEM_WORDS; i++) begin
      rdat = 16'($urandom);
      access(1'b1, R_DATA, rdat, $urandom_range(1, 2), 1'b0, 16'h0, 1'b0);
    end

    // Sequential write / read-back
    wr(R_ADDR, 16'h0010);
    wr(R_DATA, 16'h1111);
    wr(R_DATA, 16'h2222);
    wr(R_DATA, 16'h3333);
    wr(R_ADDR, 16'h0010);
    rd(R_DATA); rd(R_DATA); rd(R_DATA);
    rd(R_ADDR);

    // Address wrap and out-of-range accesses
    wr(R_ADDR, 16'hFFFE);
    wr(R_DATA, 16'hAAAA);
    rd(R_ADDR);
    wr(R_ADDR, 16'h0800);
    wr(R_DATA, 16'h5555);
    wr(R_ADDR, 16'h0800);
    rd(R_DATA);
    wr(R_ADDR, 16'h0000);
    rd(R_DATA);
    wr(R_ADDR, 16'h07FE);
    rd(R_DATA);

    // Host-to-device mailbox and overrun
    wr(R_MBX, 16'hBEEF);
    check_flags();
    wr(R_MBX, 16'hCAFE);
    check_flags();
    rd(R_STAT);
    rd(R_STAT);
    dev_pulse(1'b0, 16'h0, 1'b1);
    check_flags();

    // Device-to-host mailbox and collision with a host read
    dev_pulse(1'b1, 16'h1234, 1'b0);
    check_flags();
    rd(R_MBX);
    check_flags();
    access(1'b0, R_MBX, 16'h0, 2, 1'b1, 16'h5678, 1'b0);
    check_flags();
    rd(R_MBX);
    check_flags();

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      logic [1:0]  r;
      bit          w;
      logic [15:0] d;
      r = 2'($urandom_range(0, 3));
      w = 1'($urandom_range(0, 1));
      d = 16'($urandom);
      if (r == R_ADDR && w) begin
        case ($urandom_range(0, 7))
          0:       d = 16'hFFFE;
          1:       d = 16'h0800 | (d & 16'h00FE);
          2:       d = d;
          default: d = d & 16'h07FF;
        endcase
      end
      if ($urandom_range(0, 9) == 0)
        dev_pulse(1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 1)));
      access(w, r, d, $urandom_range(1, 3),
             ($urandom_range(0, 5) == 0), 16'($urandom), ($urandom_range(0, 5) == 0));
      check_flags();
    end

    guard = 0;
    while (exp_q.size() != 0 && guard < 20) begin
      @(posedge clk);
      guard++;
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL pending_reads got=%0d required=0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/hpi_responder.md
# hpi_responder

Synthesizable responder for the OTG Host Port Interface (HPI). It sits on the far end of the `otg_hpi_*` bus that the Nios II system drives through its PIOs. It implements the CY7C67200-style HPI register set: DATA, MAILBOX, ADDRESS and STATUS. Behind that register set are a word-addressed on-chip RAM and a bidirectional mailbox with a device-side handshake. It serves as the simulation and bring-up stand-in for the USB controller and as a loopback target for driver software.

## Interface
Parameters:
- `MEM_WORDS`, default 1024: number of 16-bit RAM words; power of two, 2..32768.
- `MEM_AW`, default 10: log2(`MEM_WORDS`).

Ports:
- `clk_clk`  in  1  the single clock; all bus inputs are synchronous to it.
- `reset_reset`  in  1  reset, asynchronous, active-high.
- `otg_hpi_address`  in  2  register select: 0 = DATA, 1 = MAILBOX, 2 = ADDRESS, 3 = STATUS.
- `otg_hpi_cs_n`  in  1  chip select, active-low.
- `otg_hpi_r_n`  in  1  read strobe, active-low.
- `otg_hpi_w_n`  in  1  write strobe, active-low.
- `otg_hpi_data_in`  in  16  write data from the initiator.
- `otg_hpi_data_out`  out  16  read data to the initiator.
- `otg_hpi_data_oe`  out  1  high while the responder drives `otg_hpi_data_out`.
- `hpi_int`  out  1  interrupt to the initiator; equals STATUS bit1.
- `dev_mbx_rdata`  out  16  last host-to-device mailbox word.
- `dev_mbx_full`  out  1  host-to-device mailbox holds an unacknowledged word.
- `dev_mbx_ack`  in  1  one-cycle pulse that clears `dev_mbx_full`.
- `dev_mbx_wdata`  in  16  device-to-host mailbox word.
- `dev_mbx_wr`  in  1  one-cycle pulse that loads `dev_mbx_wdata` into the device-to-host mailbox.

## Operation
- **Active condition.** An access is active in a cycle when `otg_hpi_cs_n`=0 and exactly one of `otg_hpi_r_n` / `otg_hpi_w_n` is 0.
  - If both strobes are low, the cycle counts as inactive and has no effect.
- **Access start.** An access starts in the first active cycle after an inactive cycle (registered `prev_active`).
  - Every effect below occurs once, at access start.
  - Holding a strobe low for many cycles produces exactly one access.
- **ADDRESS register (`addr`).** 16-bit byte address.
  - A write loads `otg_hpi_data_in`.
  - A read returns `addr`.
- **DATA register.** Accesses RAM word `addr[MEM_AW:1]`, then post-increments `addr` by 2 (16-bit wrap: 0xFFFE goes to 0x0000).
  - Addresses at or above 2*`MEM_WORDS` are out of range: writes are ignored, reads return 0x0000, and the increment still happens.
  - `addr[0]` is ignored.
- **MAILBOX, host write.** Loads `dev_mbx_rdata` and sets `dev_mbx_full`.
  - If `dev_mbx_full` was already set, STATUS bit2 (overrun) is also set and the word is overwritten.
- **MAILBOX, host read.** Returns the device-to-host word and clears STATUS bit1.
- **Device mailbox write.** `dev_mbx_wr` loads the device-to-host word and sets bit1.
  - If `dev_mbx_wr` coincides with a host MAILBOX read start, the set wins: bit1 stays 1 and the host receives the old word.
- **Device acknowledge.** `dev_mbx_ack` clears `dev_mbx_full`.
  - If it coincides with a host MAILBOX write, full ends at 1 and no overrun is flagged.
- **STATUS register.** Read-only; writes are ignored.
  - Layout: bit0 = `dev_mbx_full`, bit1 = device-to-host full, bit2 = overrun, bits 15:3 = 0.
  - A read returns the pre-clear value, then clears bit2.

## Timing
- **Reset values.**
  - All outputs are 0.
  - `addr`, both mailboxes and all STATUS bits are 0.
  - RAM contents are not reset.
  - `prev_active` resets to 1, so a strobe held low through reset release is not taken as a new access until it goes inactive.
- **Write timing.** Write data and address are sampled in the access-start cycle. The register or RAM updates on that clock edge and is visible to an access starting the next cycle.
- **Read timing.** Read data is captured at access start into a read register.
  - `otg_hpi_data_out` is valid, and `otg_hpi_data_oe`=1, from the cycle after access start.
  - Both hold while the access stays active.
  - `otg_hpi_data_oe` drops the cycle after the access ends; `otg_hpi_data_out` then returns to 0.
- **Read-register behaviour.** A single-port synchronous RAM read satisfies the one-cycle read latency. Back-to-back accesses need at least one inactive cycle between them.
- **Interrupt and device-side flags.** `hpi_int` and `dev_mbx_full` are registered and update one cycle after their causing event.
- **Reset mid-access.** Reset aborts the access immediately; no partial write and no address increment.

## Test plan
- **Reset and idle bus.**
  - Stimulus: reset with strobes idle.
  - Required: all outputs 0; a STATUS read returns 0x0000.
- **Sequential RAM write/read-back.**
  - Stimulus: write ADDRESS=0x0010; write DATA 0x1111, 0x2222, 0x3333; write ADDRESS=0x0010; read DATA three times.
  - Required: reads return 0x1111, 0x2222, 0x3333; a final ADDRESS read returns 0x0016.
- **Wrap and out of range.**
  - Stimulus: ADDRESS=0xFFFE, write DATA 0xAAAA, then read ADDRESS; with ADDRESS=0x0800 (`MEM_WORDS`=1024), write 0x5555 then read DATA.
  - Required: the ADDRESS read returns 0x0000; the out-of-range read returns 0x0000 and RAM is unchanged.
- **Host-to-device mailbox and overrun.**
  - Stimulus: host writes MAILBOX 0xBEEF; host writes MAILBOX 0xCAFE without `dev_mbx_ack`.
  - Required: after the first write, `dev_mbx_full`=1 and `dev_mbx_rdata`=0xBEEF.
  - Required: after the second write, a STATUS read returns 0x0005, then a second STATUS read returns 0x0001.
- **Device-to-host mailbox and collision.**
  - Stimulus: pulse `dev_mbx_wr` with 0x1234; host reads MAILBOX; pulse `dev_mbx_wr` 0x5678 in the same cycle as a host MAILBOX read start.
  - Required: `hpi_int` rises; the host read returns 0x1234 and `hpi_int` clears.
  - Required: in the collision case, the read returns 0x1234 and `hpi_int` stays 1.
- **Strobe held across reset.**
  - Stimulus: hold `otg_hpi_w_n` low across reset release, then release the strobe and assert it again.
  - Required: no write while the strobe is held; exactly one write after it is re-asserted.
